alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` between two requesters: port 0 is the execute stage, port 1 is the branch/CSR compare path. It round-robin arbitrates per cycle with valid/ready handshakes, drives the ALU operands from the winner, and registers the result into a one-entry response slot per requester. The block sits between decode/issue and the shared ALU instance.

## Interface
- Parameters: none. Widths come from `header.vh` macros.
  - `XLEN`: 32, data width.
  - `ALUOPS`: width of the ALU operation code.
- Ports (k = 0, 1):
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_reqk_valid`  in  1  requester k presents an operation.
- `o_reqk_ready`  out  1  requester k's operation is granted this cycle.
- `i_reqk_op`  in  `ALUOPS`  ALU operation code.
- `i_reqk_data_1`  in  `XLEN`  first operand.
- `i_reqk_data_2`  in  `XLEN`  second operand.
- `o_rspk_valid`  out  1  the response slot for k holds a result.
- `i_rspk_ready`  in  1  requester k consumes the response.
- `o_rspk_result`  out  `XLEN`  registered ALU result.
- `o_alu_op`  out  `ALUOPS`  to the ALU `i_alu_op`.
- `o_alu_data_1`  out  `XLEN`  to the ALU `i_data_1`.
- `o_alu_data_2`  out  `XLEN`  to the ALU `i_data_2`.
- `i_alu_result`  in  `XLEN`  from the ALU `ow_result`.
- `o_last_grant`  out  1  round-robin pointer; the index of the last granted requester.

## Operation
- A request is transferred when valid and ready are both high on a clock edge. A response is transferred when rsp valid and rsp ready are both high on a clock edge.
- Eligibility:
  - eligible_k = `i_reqk_valid` & (slot k empty | (`o_rspk_valid` & `i_rspk_ready`)).
  - A full slot accepts a new request in the same cycle it drains (no bubble).
- Grant rules:
  - Only one eligible requester: it wins.
  - Both eligible: the winner is the requester that is not `o_last_grant`.
  - Neither eligible: no grant.
  - `o_reqk_ready` = grant_k, combinational, and at most one is high per cycle.
  - Ready for an ineligible requester is 0, even when the ALU is otherwise idle.
- ALU drive:
  - On grant, `o_alu_*` = the winner's op and operands, combinational.
  - With no grant, `o_alu_op` = `ADD` and both operands = 0, so the ALU inputs never float.
- Capture:
  - At the edge of a grant to k, slot k ← `i_alu_result`, `o_rspk_valid` ← 1, `o_last_grant` ← k.
  - Slot k with a drain and no new grant: `o_rspk_valid` ← 0 and `o_rspk_result` holds its stale value.
  - Otherwise, the slot holds.
- Each slot is independent: a stalled consumer on port 1 never blocks port 0.
- Arithmetic and width semantics belong to the ALU. This block passes all `XLEN` bits unmodified and adds no sign handling.
- Reset (synchronous, `i_rst_n`=0 at an edge):
  - Both `o_rspk_valid` ← 0, both `o_rspk_result` ← 0, `o_last_grant` ← 1, so port 0 wins the first tie.
  - While `i_rst_n`=0, both `o_reqk_ready` are forced to 0 and the ALU outputs take their idle values.
  - Reset mid-operation: responses still held in the slots are discarded, and a request presented in the reset cycle is not accepted.

## Timing
- Request-to-response latency is 1 cycle: a grant at edge N gives `o_rspk_valid`=1 after edge N.
- Throughput is one ALU operation per cycle, summed over both ports.
- A single requester streaming with `i_rspk_ready`=1 gets one result per cycle.
- Under contention each port gets every other cycle, so worst-case wait is 1 cycle.
- `o_reqk_ready` may depend combinationally on `i_rspk_ready` and on both req valids, but never on `i_alu_result`.
- Combinational path: `i_reqk_*` → `o_alu_*` → `i_alu_result` → slot register, one ALU delay per cycle.
- Outputs after reset: `o_rsp0_valid`=0, `o_rsp1_valid`=0, both results 0, `o_last_grant`=1, both readies 0 during reset.

## Test plan
- Reset, then a port 0 request with `ADD`, 5, 7 and rsp ready=1.
  - Required: `o_req0_ready`=1 the same cycle; the next cycle `o_rsp0_valid`=1 with result 12.
  - Required: `o_last_grant`=0.
- Both ports valid for 4 cycles: port 0 `SUB` 10,3; port 1 `SLT` 0xFFFFFFFF,1; both rsp ready=1.
  - Required: grants alternate 0,1,0,1.
  - Required: results are 7 on port 0 and 1 on port 1.
- Port 1 `i_rsp1_ready`=0 with port 1 request valid `XOR` 0xF0,0xFF.
  - Required: the first grant is accepted (result 0x0F) and port 1 ready stays 0 afterwards.
  - Required: port 0 keeps getting granted every cycle.
- Port 1 slot full and `i_rsp1_ready`=1 with a new `OR` 1,2.
  - Required: drain and grant happen in the same cycle; the next cycle `o_rsp1_valid` stays 1 with result 3.
- Idle with no requests.
  - Required: `o_alu_op`=`ADD`, both `o_alu_data` outputs 0, and no rsp valid change.
- Assert `i_rst_n`=0 for one edge while both slots are full and both requests are valid.
  - Required: both rsp valids and results 0 and `o_last_grant`=1 after the edge, with no grant in that cycle.
  - Required: the next tie is won by port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each port has its own registered one-entry response slot.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif
`ifndef ADD
`define ADD 4'd0
`endif

module alu_arbiter (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [`ALUOPS-1:0] i_req0_op,
  input  logic [`XLEN-1:0]   i_req0_data_1,
  input  logic [`XLEN-1:0]   i_req0_data_2,
  output logic               o_rsp0_valid,
  input  logic               i_rsp0_ready,
  output logic [`XLEN-1:0]   o_rsp0_result,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [`ALUOPS-1:0] i_req1_op,
  input  logic [`XLEN-1:0]   i_req1_data_1,
  input  logic [`XLEN-1:0]   i_req1_data_2,
  output logic               o_rsp1_valid,
  input  logic               i_rsp1_ready,
  output logic [`XLEN-1:0]   o_rsp1_result,
  output logic [`ALUOPS-1:0] o_alu_op,
  output logic [`XLEN-1:0]   o_alu_data_1,
  output logic [`XLEN-1:0]   o_alu_data_2,
  input  logic [`XLEN-1:0]   i_alu_result,
  output logic               o_last_grant
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [`XLEN-1:0] rsp_result_q [2];
  logic [`XLEN-1:0] rsp_result_d [2];
  logic             last_grant_q, last_grant_d;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // A full slot that drains this cycle can accept a new request (no bubble).
  always_comb begin
    eligible = '0;
    if (i_rst_n) begin
      eligible = req_valid & (~rsp_valid_q | rsp_ready);
    end
  end

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  always_comb begin
    o_alu_op     = `ADD;
    o_alu_data_1 = '0;
    o_alu_data_2 = '0;
    if (grant[0]) begin
      o_alu_op     = i_req0_op;
      o_alu_data_1 = i_req0_data_1;
      o_alu_data_2 = i_req0_data_2;
    end else if (grant[1]) begin
      o_alu_op     = i_req1_op;
      o_alu_data_1 = i_req1_data_1;
      o_alu_data_2 = i_req1_data_2;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_comb begin
        rsp_valid_d[gi]  = rsp_valid_q[gi];
        rsp_result_d[gi] = rsp_result_q[gi];
        if (grant[gi]) begin
          rsp_valid_d[gi]  = 1'b1;
          rsp_result_d[gi] = i_alu_result;
        end else if (rsp_valid_q[gi] && rsp_ready[gi]) begin
          rsp_valid_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_valid_q     <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
      last_grant_q    <= 1'b1;
    end else begin
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q[0] <= rsp_result_d[0];
      rsp_result_q[1] <= rsp_result_d[1];
      last_grant_q    <= last_grant_d;
    end
  end

  assign o_req0_ready  = grant[0];
  assign o_req1_ready  = grant[1];
  assign o_rsp0_valid  = rsp_valid_q[0];
  assign o_rsp1_valid  = rsp_valid_q[1];
  assign o_rsp0_result = rsp_result_q[0];
  assign o_rsp1_result = rsp_result_q[1];
  assign o_last_grant  = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model
// and a combinational ALU stand-in driven by the arbiter's ALU outputs.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif
`ifndef ADD
`define ADD 4'd0
`endif

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = `ADD;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_d1, req0_d2, req1_d1, req1_d2;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_d1, alu_d2, alu_result;
  logic        last_grant;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
    .i_req0_data_1(req0_d1), .i_req0_data_2(req0_d2),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_result(rsp0_result),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
    .i_req1_data_1(req1_d1), .i_req1_data_2(req1_d2),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_result(rsp1_result),
    .o_alu_op(alu_op), .o_alu_data_1(alu_d1), .o_alu_data_2(alu_d2),
    .i_alu_result(alu_result), .o_last_grant(last_grant)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_d1, alu_d2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents and round-robin pointer.
  bit          m_on = 1'b0;
  logic        m_vld [2];
  logic [31:0] m_res [2];
  logic        m_last;

  // Returns the winning port (0/1), or -1 for no grant.
  function automatic int model_winner();
    bit e0, e1;
    e0 = rst_n && req0_valid && (!m_vld[0] || rsp0_ready);
    e1 = rst_n && req1_valid && (!m_vld[1] || rsp1_ready);
    if (e0 && e1) return (m_last == 1'b1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      int w;
      w = model_winner();
      check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
      check("alu_op", {28'd0, alu_op}, {28'd0, (w == 0) ? req0_op : (w == 1) ? req1_op : OP_ADD});
      check("alu_d1", alu_d1, (w == 0) ? req0_d1 : (w == 1) ? req1_d1 : 32'd0);
      check("alu_d2", alu_d2, (w == 0) ? req0_d2 : (w == 1) ? req1_d2 : 32'd0);
      check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_vld[0]});
      check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_vld[1]});
      check("rsp0_result", rsp0_result, m_res[0]);
      check("rsp1_result", rsp1_result, m_res[1]);
      check("last_grant", {31'd0, last_grant}, {31'd0, m_last});
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on   = 1'b1;
      m_vld[0] = 1'b0; m_vld[1] = 1'b0;
      m_res[0] = 32'd0; m_res[1] = 32'd0;
      m_last = 1'b1;
    end else if (m_on) begin
      int w;
      w = model_winner();
      if (m_vld[0] && rsp0_ready) m_vld[0] = 1'b0;
      if (m_vld[1] && rsp1_ready) m_vld[1] = 1'b0;
      if (w == 0) begin
        m_vld[0] = 1'b1; m_res[0] = alu_f(req0_op, req0_d1, req0_d2); m_last = 1'b0;
      end else if (w == 1) begin
        m_vld[1] = 1'b1; m_res[1] = alu_f(req1_op, req1_d1, req1_d2); m_last = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = OP_ADD; req1_op = OP_ADD;
    req0_d1 = 0; req0_d2 = 0; req1_d1 = 0; req1_d2 = 0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    req0_valid = 1'b1;
    tick();
    #1;
    check("reset_ready0", {31'd0, req0_ready}, 32'd0);
    check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("reset_rsp0_result", rsp0_result, 32'd0);
    check("reset_rsp1_result", rsp1_result, 32'd0);
    check("reset_last_grant", {31'd0, last_grant}, 32'd1);

    // Single ADD on port 0.
    rst_n = 1'b1;
    req0_op = OP_ADD; req0_d1 = 32'd5; req0_d2 = 32'd7; rsp0_ready = 1'b1;
    #1;
    check("add_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    check("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("add_rsp0_result", rsp0_result, 32'd12);
    check("add_last_grant", {31'd0, last_grant}, 32'd0);
    $display("[TB] txn add p0 5+7 -> %0d", rsp0_result);

    // Lone port 1 request moves the pointer to 1.
    req1_valid = 1'b1; req1_op = OP_ADD; req1_d1 = 32'd1; req1_d2 = 32'd1; rsp1_ready = 1'b1;
    tick();
    check("p1_add_result", rsp1_result, 32'd2);
    check("p1_last_grant", {31'd0, last_grant}, 32'd1);

    // Contention: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_op = OP_SUB; req0_d1 = 32'd10; req0_d2 = 32'd3;
    req1_valid = 1'b1; req1_op = OP_SLT; req1_d1 = 32'hFFFF_FFFF; req1_d2 = 32'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      check("rr_ready1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      tick();
      if ((i % 2) == 0) check("rr_sub_result", rsp0_result, 32'd7);
      else              check("rr_slt_result", rsp1_result, 32'd1);
      $display("[TB] txn rr cycle %0d granted p%0d", i, i % 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Port 1 consumer stalled: one XOR accepted, then port 0 streams alone.
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_d1 = 32'hF0; req1_d2 = 32'hFF;
    for (int i = 0; i < 5; i++) begin
      req0_d1 = i; req0_d2 = i;
      #1;
      check("stall_ready0", {31'd0, req0_ready}, {31'd0, i != 1});
      check("stall_ready1", {31'd0, req1_ready}, {31'd0, i == 1});
      tick();
      if (i == 1) check("stall_xor_result", rsp1_result, 32'h0F);
      else        check("stall_p0_result", rsp0_result, 32'(2 * i));
      $display("[TB] txn stall cycle %0d p0=%0h p1=%0h", i, rsp0_result, rsp1_result);
    end
    check("stall_rsp1_held", {31'd0, rsp1_valid}, 32'd1);

    // Drain and refill port 1 in the same cycle.
    req0_valid = 1'b0;
    rsp1_ready = 1'b1; req1_op = OP_OR; req1_d1 = 32'd1; req1_d2 = 32'd2;
    #1;
    check("refill_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    check("refill_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("refill_rsp1_result", rsp1_result, 32'd3);
    $display("[TB] txn or p1 1|2 -> %0d", rsp1_result);

    // Idle: ALU inputs at their quiet values, slots unchanged.
    req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("idle_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
    check("idle_alu_d1", alu_d1, 32'd0);
    check("idle_alu_d2", alu_d2, 32'd0);
    tick();
    check("idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("idle_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("idle_rsp1_result", rsp1_result, 32'd3);

    // Fill slot 0 so both slots are full, then reset mid-operation.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_d1 = 32'd1; req0_d2 = 32'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_d1 = 32'd2; req1_d2 = 32'd2;
    tick();
    check("full_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    rst_n = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
    tick();
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    check("rst_rsp1_result", rsp1_result, 32'd0);
    check("rst_last_grant", {31'd0, last_grant}, 32'd1);
    rst_n = 1'b1;
    #1;
    check("post_rst_tie_ready0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_tie_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("post_rst_result", rsp0_result, 32'd2);
    check("post_rst_last_grant", {31'd0, last_grant}, 32'd0);
    $display("[TB] txn post-reset tie won by p0 -> %0d", rsp0_result);

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
